serial_word_packer: RTL and testbench



---
 rtl/serial_packer_pkg.sv | 16 +
 rtl/serial_shift_reg.sv | 33 +++
 rtl/serial_word_packer.sv | 111 +++++++++++
 tb/tb_serial_word_packer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_packer_pkg.sv
// Shared types and sizing helpers for the serial word packer.
// Optional parity output is enabled with SERIAL_PACKER_PARITY_EN.
package serial_packer_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int COUNT_W = 8;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in parallel-out shift register feeding the word packer.
// word_next is the word as it will look once bit_in is shifted in.
module serial_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] word_next
);

  // first bit must end at the chosen end after WIDTH shifts
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next = {word[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign word_next = {bit_in, word[WIDTH-1:1]};
    end
  endgenerate

  // shift only on an accepted bit so idle X on bit_in never lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (en) begin
      word <= word_next;
    end
  end

endmodule

// File: rtl/serial_word_packer.sv
// Packs a serial bit stream into WIDTH-bit words with a valid/ready output.
// Define SERIAL_PACKER_PARITY_EN to add the registered word_parity port.
module serial_word_packer
  import serial_packer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [WIDTH-1:0]   word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [COUNT_W-1:0] word_count
`ifdef SERIAL_PACKER_PARITY_EN
  ,
  output logic               word_parity
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr_word;
  logic [WIDTH-1:0] sr_next;
  logic             accept;
  logic             take;
  logic             last;
  logic             load_fill;
  logic             load_stall;
  logic             load;
  logic [WIDTH-1:0] load_word;

  assign bit_ready  = (state == FILL);
  assign accept     = bit_valid & bit_ready;
  assign take       = word_valid & word_ready;
  assign last       = (cnt == LAST);
  assign load_fill  = accept & last & (~word_valid | word_ready);
  assign load_stall = (state == STALL) & take;
  assign load       = load_fill | load_stall;
  assign load_word  = load_stall ? sr_word : sr_next;

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk       (clk),
    .rst       (rst),
    .en        (accept),
    .bit_in    (bit_in),
    .word      (sr_word),
    .word_next (sr_next)
  );

  // fill/stall control, bit counter, output register and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
    end else begin
      if (load) begin
        word_out   <= load_word;
        word_valid <= 1'b1;
      end else if (take) begin
        word_valid <= 1'b0;
      end
      if (take) begin
        word_count <= word_count + COUNT_W'(1);
      end
      unique case (state)
        FILL: begin
          if (accept) begin
            if (!last) begin
              cnt <= cnt + CNT_W'(1);
            end else begin
              cnt <= '0;
              if (!load_fill) begin
                state <= STALL;
              end
            end
          end
        end
        STALL: begin
          if (take) begin
            state <= FILL;
          end
        end
      endcase
    end
  end

`ifdef SERIAL_PACKER_PARITY_EN
  // parity travels with word_out so it always describes the held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_parity <= 1'b0;
    end else if (load) begin
      word_parity <= ^load_word;
    end
  end
`endif

endmodule

// File: tb/tb_serial_word_packer.sv
// Randomized and directed bench for serial_word_packer (LSB- and MSB-first).
// Reference is a queue of completed words holding at most two entries.
module tb_serial_word_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bv = 1'b0;
  logic       bi = 1'b0;
  logic       wr = 1'b0;
  logic       rdy_l, rdy_m;
  logic       val_l, val_m;
  logic [7:0] out_l, out_m;
  logic [7:0] cnt_l, cnt_m;
`ifdef SERIAL_PACKER_PARITY_EN
  logic       par_l, par_m;
`endif

  always #5 clk = ~clk;

  serial_word_packer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bi), .bit_valid(bv),
    .bit_ready(rdy_l), .word_out(out_l), .word_valid(val_l),
    .word_ready(wr), .word_count(cnt_l)
`ifdef SERIAL_PACKER_PARITY_EN
    , .word_parity(par_l)
`endif
  );

  serial_word_packer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bi), .bit_valid(bv),
    .bit_ready(rdy_m), .word_out(out_m), .word_valid(val_m),
    .word_ready(wr), .word_count(cnt_m)
`ifdef SERIAL_PACKER_PARITY_EN
    , .word_parity(par_m)
`endif
  );

  int          compared = 0;
  int          mismatched = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  q_l[$];
  logic [7:0]  q_m[$];
  int          nbits = 0;
  logic [7:0]  acc_l = '0;
  logic [7:0]  acc_m = '0;
  int unsigned takes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_l.delete();
    q_m.delete();
    nbits = 0;
    acc_l = '0;
    acc_m = '0;
    takes = 0;
  endtask

  // one clock edge of the reference: pop on take, push on WIDTH-th bit
  task automatic model_step(input logic v, input logic b, input logic r);
    bit take, acc;
    take = (q_l.size() > 0) && r;
    acc  = v && (q_l.size() < 2);
    if (take) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
      takes++;
    end
    if (acc) begin
      acc_l[nbits] = b;
      acc_m[7 - nbits] = b;
      nbits++;
      if (nbits == 8) begin
        q_l.push_back(acc_l);
        q_m.push_back(acc_m);
        nbits = 0;
      end
    end
  endtask

  task automatic tick(input logic v, input logic b, input logic r);
    bv = v;
    bi = v ? b : 1'bx;
    wr = r;
    @(posedge clk);
    #1;
    model_step(v, b, r);
  endtask

  task automatic send_word(input logic [7:0] w, input logic r);
    for (int k = 0; k < 8; k++) tick(1'b1, w[k], r);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    bv = 1'b0;
    wr = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, val_l}, 32'h0);
    chk("rst_out", {24'b0, out_l}, 32'h0);
    chk("rst_out_msb", {24'b0, out_m}, 32'h0);
    chk("rst_count", {24'b0, cnt_l}, 32'h0);
`ifdef SERIAL_PACKER_PARITY_EN
    chk("rst_parity", {31'b0, par_l}, 32'h0);
`endif
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  // per-cycle comparison against the reference queue
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {31'b0, val_l}, {31'b0, q_l.size() > 0});
      chk("valid_msb", {31'b0, val_m}, {31'b0, q_m.size() > 0});
      chk("bit_ready", {31'b0, rdy_l}, {31'b0, q_l.size() < 2});
      chk("bit_ready_msb", {31'b0, rdy_m}, {31'b0, q_m.size() < 2});
      chk("count", {24'b0, cnt_l}, takes % 256);
      chk("count_msb", {24'b0, cnt_m}, takes % 256);
      if (q_l.size() > 0) begin
        chk("word", {24'b0, out_l}, {24'b0, q_l[0]});
        chk("word_msb", {24'b0, out_m}, {24'b0, q_m[0]});
`ifdef SERIAL_PACKER_PARITY_EN
        chk("parity", {31'b0, par_l}, {31'b0, ^q_l[0]});
        chk("parity_msb", {31'b0, par_m}, {31'b0, ^q_m[0]});
`endif
      end
    end
  end

  initial begin
    do_reset();

    // basic pack: 1,0,1,1,0,0,0,1
    send_word(8'h8D, 1'b1);
    @(negedge clk);
    chk("basic_lsb", {24'b0, out_l}, 32'h8D);
    chk("basic_msb", {24'b0, out_m}, 32'hB1);
    chk("basic_valid", {31'b0, val_l}, 32'h1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("basic_drop", {31'b0, val_l}, 32'h0);
    chk("basic_count", {24'b0, cnt_l}, 32'h1);

    // backpressure: FF then 00 with consumer stalled
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_ready", {31'b0, rdy_l}, 32'h0);
    chk("bp_hold", {24'b0, out_l}, 32'hFF);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_next", {24'b0, out_l}, 32'h00);
    chk("bp_ready2", {31'b0, rdy_l}, 32'h1);
    chk("bp_count1", {24'b0, cnt_l}, 32'h2);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_count2", {24'b0, cnt_l}, 32'h3);

    // last bit of word 2 on the same edge word 1 is taken
    send_word(8'h5A, 1'b0);
    for (int k = 0; k < 7; k++) tick(1'b1, k[0] ? 1'b0 : 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("sim_valid", {31'b0, val_l}, 32'h1);
    chk("sim_word", {24'b0, out_l}, 32'h80);
    chk("sim_word_msb", {24'b0, out_m}, 32'h01);
    chk("sim_count", {24'b0, cnt_l}, 32'h4);
    tick(1'b0, 1'b0, 1'b1);

    // randomized traffic, two backpressure regimes
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 3) != 0, 1'($urandom),
           (i < 750) ? ($urandom_range(0, 3) != 0)
                     : ($urandom_range(0, 3) == 0));
    end

    // reset mid-word, then a clean word
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(8'hC5, 1'b1);
    @(negedge clk);
    chk("clean_word", {24'b0, out_l}, 32'hC5);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("clean_count", {24'b0, cnt_l}, 32'h1);

    // 255 more words wrap the counter to 0
    for (int w = 0; w < 255; w++) send_word(8'($urandom), 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap_count", {24'b0, cnt_l}, 32'h0);

`ifdef SERIAL_PACKER_PARITY_EN
    send_word(8'h07, 1'b1);
    @(negedge clk);
    chk("parity_07", {31'b0, par_l}, 32'h1);
    send_word(8'h03, 1'b1);
    @(negedge clk);
    chk("parity_03", {31'b0, par_l}, 32'h0);
    tick(1'b0, 1'b0, 1'b1);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
